// File: rtl/mem_dual_sync_if.sv
// Request/response bundle for the dual-port memory: port A fetch (read-only), port B load/store.
// The memory side uses the slave modport; the requester side uses the master modport.
interface mem_dual_sync_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_W = DATA_WIDTH / 8;

  logic                  pMemA_bReqValid;
  logic                  pMemA_bReqReady;
  logic [ADDR_WIDTH-1:0] pMemA_bReqAddr;
  logic                  pMemA_bRspValid;
  logic                  pMemA_bRspReady;
  logic [DATA_WIDTH-1:0] pMemA_bRspData;
  logic                  pMemA_bRspErr;

  logic                  pMemB_bReqValid;
  logic                  pMemB_bReqReady;
  logic                  pMemB_bReqWr;
  logic [ADDR_WIDTH-1:0] pMemB_bReqAddr;
  logic [DATA_WIDTH-1:0] pMemB_bReqData;
  logic [MASK_W-1:0]     pMemB_bReqMask;
  logic                  pMemB_bRspValid;
  logic                  pMemB_bRspReady;
  logic [DATA_WIDTH-1:0] pMemB_bRspData;
  logic                  pMemB_bRspErr;

  modport master (
    output pMemA_bReqValid, pMemA_bReqAddr, pMemA_bRspReady,
    input  pMemA_bReqReady, pMemA_bRspValid, pMemA_bRspData, pMemA_bRspErr,
    output pMemB_bReqValid, pMemB_bReqWr, pMemB_bReqAddr, pMemB_bReqData, pMemB_bReqMask,
    output pMemB_bRspReady,
    input  pMemB_bReqReady, pMemB_bRspValid, pMemB_bRspData, pMemB_bRspErr
  );

  modport slave (
    input  pMemA_bReqValid, pMemA_bReqAddr, pMemA_bRspReady,
    output pMemA_bReqReady, pMemA_bRspValid, pMemA_bRspData, pMemA_bRspErr,
    input  pMemB_bReqValid, pMemB_bReqWr, pMemB_bReqAddr, pMemB_bReqData, pMemB_bReqMask,
    input  pMemB_bRspReady,
    output pMemB_bReqReady, pMemB_bRspValid, pMemB_bRspData, pMemB_bRspErr
  );
endinterface

// File: rtl/mem_dual_sync.sv
// Dual-port word memory: port A read-only fetch, port B masked load/store, registered responses.
// Optional macro MEM_BYPASS_EN: a same-cycle A read / B store collision returns the merged new word on A.
module mem_dual_sync #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_dual_sync_if.slave    bus
);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int LG     = $clog2(MASK_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_a_state, r_b_state;
  logic [DATA_WIDTH-1:0] r_a_data_p1, r_b_data_p1;
  logic                  r_a_err_p1, r_b_err_p1;

  logic [ADDR_WIDTH-1:0] w_a_off, w_b_off;
  logic [IDX_W-1:0]      w_a_idx, w_b_idx;
  logic                  w_a_err, w_b_err;
  logic                  w_a_acc, w_b_acc, w_b_store;
  logic [DATA_WIDTH-1:0] w_a_rdata;

  // Offset is taken modulo 2^ADDR_WIDTH; the explicit addr < BASE test catches wrap-around.
  function automatic logic range_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH-1:0] off);
    return (addr < BASE_ADDR) || ((off >> LG) >= ADDR_WIDTH'(DEPTH)) || (off[LG-1:0] != '0);
  endfunction

  assign w_a_off   = bus.pMemA_bReqAddr - BASE_ADDR;
  assign w_b_off   = bus.pMemB_bReqAddr - BASE_ADDR;
  assign w_a_idx   = w_a_off[LG +: IDX_W];
  assign w_b_idx   = w_b_off[LG +: IDX_W];
  assign w_a_err   = range_err(bus.pMemA_bReqAddr, w_a_off);
  assign w_b_err   = range_err(bus.pMemB_bReqAddr, w_b_off);

  assign bus.pMemA_bRspValid = (r_a_state == S_BUSY);
  assign bus.pMemB_bRspValid = (r_b_state == S_BUSY);
  assign bus.pMemA_bReqReady = !bus.pMemA_bRspValid || bus.pMemA_bRspReady;
  assign bus.pMemB_bReqReady = !bus.pMemB_bRspValid || bus.pMemB_bRspReady;
  assign bus.pMemA_bRspData  = r_a_data_p1;
  assign bus.pMemB_bRspData  = r_b_data_p1;
  assign bus.pMemA_bRspErr   = r_a_err_p1;
  assign bus.pMemB_bRspErr   = r_b_err_p1;

  assign w_a_acc   = bus.pMemA_bReqValid && bus.pMemA_bReqReady;
  assign w_b_acc   = bus.pMemB_bReqValid && bus.pMemB_bReqReady;
  assign w_b_store = w_b_acc && bus.pMemB_bReqWr && !w_b_err;

`ifdef MEM_BYPASS_EN
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [MASK_W-1:0]     mask);
    logic [DATA_WIDTH-1:0] res;
    for (int i = 0; i < MASK_W; i++)
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

  assign w_a_rdata = (w_b_store && (w_a_idx == w_b_idx))
                   ? merge_bytes(r_mem[w_a_idx], bus.pMemB_bReqData, bus.pMemB_bReqMask)
                   : r_mem[w_a_idx];
`else
  assign w_a_rdata = r_mem[w_a_idx];
`endif

  // Stage p0 -> p1: array write commits only at the accept edge, never while in reset.
  always_ff @(posedge clock) begin
    if (w_b_store && reset_n) begin
      for (int i = 0; i < MASK_W; i++)
        if (bus.pMemB_bReqMask[i])
          r_mem[w_b_idx][8*i +: 8] <= bus.pMemB_bReqData[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_state   <= S_IDLE;
      r_a_data_p1 <= '0;
      r_a_err_p1  <= 1'b0;
    end else begin
      case (r_a_state)
        S_IDLE: if (w_a_acc) r_a_state <= S_BUSY;
        S_BUSY: if (bus.pMemA_bRspReady && !w_a_acc) r_a_state <= S_IDLE;
        default: r_a_state <= S_IDLE;
      endcase
      if (w_a_acc) begin
        r_a_err_p1  <= w_a_err;
        r_a_data_p1 <= w_a_err ? '0 : w_a_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_b_state   <= S_IDLE;
      r_b_data_p1 <= '0;
      r_b_err_p1  <= 1'b0;
    end else begin
      case (r_b_state)
        S_IDLE: if (w_b_acc) r_b_state <= S_BUSY;
        S_BUSY: if (bus.pMemB_bRspReady && !w_b_acc) r_b_state <= S_IDLE;
        default: r_b_state <= S_IDLE;
      endcase
      if (w_b_acc) begin
        r_b_err_p1  <= w_b_err;
        r_b_data_p1 <= (w_b_err || bus.pMemB_bReqWr) ? '0 : r_mem[w_b_idx];
      end
    end
  end
endmodule

// File: tb/tb_mem_dual_sync.sv
// Directed bench for mem_dual_sync: a word-array/response-queue model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_mem_dual_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_dual_sync_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_dual_sync #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4096), .BASE_ADDR(32'h8000_0000)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct { logic [31:0] d; logic e; } rsp_t;
  logic [31:0] mm [4096];
  rsp_t qa[$];
  rsp_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua < 64'h8000_0000) || (ua >= 64'h8000_0000 + 4 * 4096) || (a[1:0] != 2'b00);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - 64'h8000_0000) / 4);
  endfunction

  initial for (int i = 0; i < 4096; i++) mm[i] = 32'h0;

  always @(negedge rst_n) begin
    qa.delete();
    qb.delete();
  end

  // Model: what each accepted request must return, and how the word array changes.
  always @(posedge clk) begin : model
    bit acc_a, acc_b, st_ok, ba, bb;
    rsp_t ra, rb;
    int ia, ib;
    logic [31:0] nw;
    if (rst_n) begin
      acc_a = bus.pMemA_bReqValid && (qa.size() == 0 || bus.pMemA_bRspReady);
      acc_b = bus.pMemB_bReqValid && (qb.size() == 0 || bus.pMemB_bRspReady);
      ba = bad_addr(bus.pMemA_bReqAddr);
      bb = bad_addr(bus.pMemB_bReqAddr);
      ia = ba ? 0 : word_of(bus.pMemA_bReqAddr);
      ib = bb ? 0 : word_of(bus.pMemB_bReqAddr);
      st_ok = acc_b && bus.pMemB_bReqWr && !bb;
      nw = mm[ib];
      for (int k = 0; k < 4; k++)
        if (bus.pMemB_bReqMask[k]) nw[8*k +: 8] = bus.pMemB_bReqData[8*k +: 8];
      ra.e = ba;
      ra.d = ba ? 32'h0 : mm[ia];
`ifdef MEM_BYPASS_EN
      if (!ba && st_ok && ia == ib) ra.d = nw;
`endif
      rb.e = bb;
      rb.d = (bb || bus.pMemB_bReqWr) ? 32'h0 : mm[ib];
      if (qa.size() != 0 && bus.pMemA_bRspReady) void'(qa.pop_front());
      if (qb.size() != 0 && bus.pMemB_bRspReady) void'(qb.pop_front());
      if (acc_a) qa.push_back(ra);
      if (acc_b) qb.push_back(rb);
      if (st_ok) mm[ib] = nw;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_a_valid", {31'b0, bus.pMemA_bRspValid}, 32'h0);
      chk("rst_b_valid", {31'b0, bus.pMemB_bRspValid}, 32'h0);
    end else begin
      chk("a_valid", {31'b0, bus.pMemA_bRspValid}, {31'b0, qa.size() != 0});
      chk("b_valid", {31'b0, bus.pMemB_bRspValid}, {31'b0, qb.size() != 0});
      chk("a_ready", {31'b0, bus.pMemA_bReqReady}, {31'b0, qa.size() == 0 || bus.pMemA_bRspReady});
      chk("b_ready", {31'b0, bus.pMemB_bReqReady}, {31'b0, qb.size() == 0 || bus.pMemB_bRspReady});
      if (qa.size() != 0) begin
        chk("a_data", bus.pMemA_bRspData, qa[0].d);
        chk("a_err", {31'b0, bus.pMemA_bRspErr}, {31'b0, qa[0].e});
      end
      if (qb.size() != 0) begin
        chk("b_data", bus.pMemB_bRspData, qb[0].d);
        chk("b_err", {31'b0, bus.pMemB_bRspErr}, {31'b0, qb[0].e});
      end
    end
  end

  task automatic a_read(input logic [31:0] addr, output logic [31:0] d, output logic e);
    @(negedge clk); #1;
    bus.pMemA_bReqValid = 1'b1;
    bus.pMemA_bReqAddr  = addr;
    @(negedge clk); #1;
    bus.pMemA_bReqValid = 1'b0;
    chk("a_rsp_next_cycle", {31'b0, bus.pMemA_bRspValid}, 32'h1);
    d = bus.pMemA_bRspData;
    e = bus.pMemA_bRspErr;
  endtask

  task automatic b_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, output logic [31:0] d, output logic e);
    @(negedge clk); #1;
    bus.pMemB_bReqValid = 1'b1;
    bus.pMemB_bReqWr    = wr;
    bus.pMemB_bReqAddr  = addr;
    bus.pMemB_bReqData  = data;
    bus.pMemB_bReqMask  = mask;
    @(negedge clk); #1;
    bus.pMemB_bReqValid = 1'b0;
    chk("b_rsp_next_cycle", {31'b0, bus.pMemB_bRspValid}, 32'h1);
    d = bus.pMemB_bRspData;
    e = bus.pMemB_bRspErr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] d, held;
    logic e;
    bus.pMemA_bReqValid = 1'b0; bus.pMemA_bReqAddr = 32'h8000_0000; bus.pMemA_bRspReady = 1'b1;
    bus.pMemB_bReqValid = 1'b0; bus.pMemB_bReqWr = 1'b0; bus.pMemB_bReqAddr = 32'h8000_0000;
    bus.pMemB_bReqData  = 32'h0; bus.pMemB_bReqMask = 4'h0; bus.pMemB_bRspReady = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_a_data", bus.pMemA_bRspData, 32'h0);
    chk("reset_a_err", {31'b0, bus.pMemA_bRspErr}, 32'h0);
    chk("reset_b_data", bus.pMemB_bRspData, 32'h0);
    chk("reset_b_err", {31'b0, bus.pMemB_bRspErr}, 32'h0);
    #1 rst_n = 1'b1;

    // Full-word store then fetch
    b_op(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, d, e);
    chk("store_rsp_data", d, 32'h0);
    chk("store_rsp_err", {31'b0, e}, 32'h0);
    a_read(32'h8000_0010, d, e);
    chk("fetch_deadbeef", d, 32'hDEAD_BEEF);
    chk("fetch_deadbeef_err", {31'b0, e}, 32'h0);

    // Byte-masked store then load
    b_op(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, d, e);
    b_op(1'b0, 32'h8000_0010, 32'h0, 4'b0000, d, e);
    chk("masked_load", d, 32'hDE22_BE44);

    // Range and alignment errors; stores to bad addresses are dropped
    b_op(1'b1, 32'h8000_0000, 32'h0BAD_C0DE, 4'b1111, d, e);
    a_read(32'h7FFF_FFFC, d, e);
    chk("below_base_err", {31'b0, e}, 32'h1);
    chk("below_base_data", d, 32'h0);
    a_read(32'h8000_4000, d, e);
    chk("past_end_err", {31'b0, e}, 32'h1);
    chk("past_end_data", d, 32'h0);
    a_read(32'h8000_0002, d, e);
    chk("misaligned_err", {31'b0, e}, 32'h1);
    chk("misaligned_data", d, 32'h0);
    b_op(1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'b1111, d, e);
    chk("bad_store_err", {31'b0, e}, 32'h1);
    b_op(1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'b1111, d, e);
    chk("misaligned_store_err", {31'b0, e}, 32'h1);
    b_op(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, d, e);
    chk("mask0_store_err", {31'b0, e}, 32'h0);
    a_read(32'h8000_0000, d, e);
    chk("word0_unchanged", d, 32'h0BAD_C0DE);
    a_read(32'h8000_0010, d, e);
    chk("word4_unchanged", d, 32'hDE22_BE44);

    // Same-cycle A fetch and B store to one word
    b_op(1'b1, 32'h8000_0020, 32'h0, 4'b1111, d, e);
    @(negedge clk); #1;
    bus.pMemA_bReqValid = 1'b1; bus.pMemA_bReqAddr = 32'h8000_0020;
    bus.pMemB_bReqValid = 1'b1; bus.pMemB_bReqWr = 1'b1; bus.pMemB_bReqAddr = 32'h8000_0020;
    bus.pMemB_bReqData  = 32'hCAFE_F00D; bus.pMemB_bReqMask = 4'b1111;
    @(negedge clk); #1;
    bus.pMemA_bReqValid = 1'b0; bus.pMemB_bReqValid = 1'b0;
`ifdef MEM_BYPASS_EN
    chk("collision_a", bus.pMemA_bRspData, 32'hCAFE_F00D);
`else
    chk("collision_a", bus.pMemA_bRspData, 32'h0);
`endif
    a_read(32'h8000_0020, d, e);
    chk("collision_after", d, 32'hCAFE_F00D);

    // Backpressure holds the response and blocks new requests, then 1/cycle streaming
    for (int i = 0; i < 4; i++) b_op(1'b1, 32'h8000_0030 + 4 * i, 32'h100 + i, 4'b1111, d, e);
    @(negedge clk); #1;
    bus.pMemA_bRspReady = 1'b0;
    bus.pMemA_bReqValid = 1'b1; bus.pMemA_bReqAddr = 32'h8000_0030;
    @(negedge clk); #1;
    held = bus.pMemA_bRspData;
    chk("bp_first_data", held, 32'h100);
    bus.pMemA_bReqAddr = 32'h8000_0034;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("bp_req_ready_low", {31'b0, bus.pMemA_bReqReady}, 32'h0);
      chk("bp_rsp_held", bus.pMemA_bRspData, held);
    end
    bus.pMemA_bRspReady = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("b2b_valid", {31'b0, bus.pMemA_bRspValid}, 32'h1);
      chk("b2b_data", bus.pMemA_bRspData, 32'h100 + i);
      if (i < 3) bus.pMemA_bReqAddr = 32'h8000_0030 + 4 * (i + 1);
      else bus.pMemA_bReqValid = 1'b0;
    end

    // Asynchronous reset while both ports hold a pending response
    @(negedge clk); #1;
    bus.pMemA_bRspReady = 1'b0; bus.pMemB_bRspReady = 1'b0;
    bus.pMemA_bReqValid = 1'b1; bus.pMemA_bReqAddr = 32'h8000_0030;
    bus.pMemB_bReqValid = 1'b1; bus.pMemB_bReqWr = 1'b0; bus.pMemB_bReqAddr = 32'h8000_0034;
    @(negedge clk); #1;
    bus.pMemA_bReqValid = 1'b0; bus.pMemB_bReqValid = 1'b0;
    chk("busy_a_before_rst", {31'b0, bus.pMemA_bRspValid}, 32'h1);
    chk("busy_b_before_rst", {31'b0, bus.pMemB_bRspValid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a_valid", {31'b0, bus.pMemA_bRspValid}, 32'h0);
    chk("async_rst_b_valid", {31'b0, bus.pMemB_bRspValid}, 32'h0);
    chk("async_rst_a_data", bus.pMemA_bRspData, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus.pMemA_bRspReady = 1'b1; bus.pMemB_bRspReady = 1'b1;
    a_read(32'h8000_0038, d, e);
    chk("post_rst_fetch", d, 32'h102);
    b_op(1'b0, 32'h8000_003C, 32'h0, 4'b0000, d, e);
    chk("post_rst_load", d, 32'h103);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
